// File: rtl/novacore_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : novacore_tile_scheduler
// Purpose  : Avalon-MM controlled tile dispatcher for a small array of
//            NovaCORE compute cores. A job covers a D x D tile grid. Tiles
//            are handed out in row-major order, one per cycle at most, to
//            idle cores chosen round-robin. The block then waits for all
//            cores to finish and raises done_flag / irq.
// Ports    : clk, reset (sync, active-high)
//            address/chipselect/write_n/writedata/readdata : register slave
//            core_start/tile_row/tile_col : dispatch to cores
//            core_done : per-core completion pulses
//            irq : done_flag AND irq_en
// Revision : 1.0 - initial release
// ============================================================================
module novacore_tile_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int DIM_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic [NUM_CORES-1:0] core_start,
  output logic [DIM_W-1:0]     tile_row,
  output logic [DIM_W-1:0]     tile_col,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 irq
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CORES - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_DIM    = 3'd2;
  localparam logic [2:0] A_TILES  = 3'd3;
  localparam logic [2:0] A_CYCLES = 3'd4;

  logic [1:0]           state_q, state_d;
  logic [DIM_W-1:0]     dim_q;
  logic                 irq_en_q;
  logic                 done_flag_q;
  logic                 aborted_q;
  logic [7:0]           tiles_q;
  logic [31:0]          cycles_q;
  logic [DIM_W-1:0]     row_q, col_q;
  logic [PTR_W-1:0]     rr_q;
  logic [NUM_CORES-1:0] core_busy_q;

  logic                 wr_en, wr_ctrl, start_wr, abort_wr;
  logic                 start_accept, abort_accept;
  logic                 busy, dispatch_fire, last_tile;
  logic                 gnt_found;
  logic [PTR_W-1:0]     gnt_idx, cand;
  logic [NUM_CORES-1:0] gnt_onehot, done_valid;
  logic [7:0]           done_cnt;
  logic [DIM_W-1:0]     dim_m1;
  logic                 unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wr_ctrl      = wr_en && (address == A_CTRL);
  assign start_wr     = wr_ctrl & writedata[0];
  assign abort_wr     = wr_ctrl & writedata[2];
  assign start_accept = (state_q == S_IDLE) && start_wr;
  // Abort is only meaningful while tiles are still being handed out.
  assign abort_accept = (state_q == S_DISPATCH) && abort_wr;
  assign dim_m1       = dim_q - {{(DIM_W-1){1'b0}}, 1'b1};
  assign last_tile    = (row_q == dim_m1) && (col_q == dim_m1);
  // A core_done only counts for a core that actually holds a tile.
  assign done_valid   = core_done & core_busy_q;
  assign gnt_onehot   = NUM_CORES'(1) << gnt_idx;
  // The abort cycle itself issues nothing, so an abort stops dispatch at once.
  assign dispatch_fire = (state_q == S_DISPATCH) && !abort_wr && gnt_found;
  assign tile_row     = row_q;
  assign tile_col     = col_q;
  assign irq          = done_flag_q & irq_en_q;
  assign unused_wdata = ^writedata;

  // Circular search for the first idle core starting at the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = PTR_W'((int'(rr_q) + i) % NUM_CORES);
      if (!gnt_found && !core_busy_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + 8'(done_valid[i]);
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_accept) state_d = (dim_q == '0) ? S_DONE : S_DISPATCH;
      end
      S_DISPATCH: begin
        if (abort_wr)                     state_d = S_DRAIN;
        else if (dispatch_fire && last_tile) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (core_busy_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy       = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
    core_start = dispatch_fire ? gnt_onehot : '0;
  end

  // Datapath and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      dim_q       <= '0;
      irq_en_q    <= 1'b0;
      done_flag_q <= 1'b0;
      aborted_q   <= 1'b0;
      tiles_q     <= '0;
      cycles_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      rr_q        <= '0;
      core_busy_q <= '0;
    end else begin
      if (wr_en && (address == A_DIM) && !busy) dim_q <= writedata[DIM_W-1:0];
      if (wr_ctrl) irq_en_q <= writedata[1];

      if (start_accept)                                         done_flag_q <= 1'b0;
      else if (state_q == S_DONE)                               done_flag_q <= 1'b1;
      else if (wr_en && (address == A_STATUS) && writedata[1])  done_flag_q <= 1'b0;

      if (start_accept)      aborted_q <= 1'b0;
      else if (abort_accept) aborted_q <= 1'b1;

      if (start_accept) tiles_q <= '0;
      else              tiles_q <= tiles_q + done_cnt;

      if (start_accept)                  cycles_q <= '0;
      else if (busy && (cycles_q != '1)) cycles_q <= cycles_q + 32'd1;

      if (start_accept) begin
        row_q <= '0;
        col_q <= '0;
      end else if (dispatch_fire) begin
        if (col_q == dim_m1) begin
          col_q <= '0;
          row_q <= row_q + {{(DIM_W-1){1'b0}}, 1'b1};
        end else begin
          col_q <= col_q + {{(DIM_W-1){1'b0}}, 1'b1};
        end
      end

      if (dispatch_fire) rr_q <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;

      core_busy_q <= (core_busy_q & ~done_valid) | (dispatch_fire ? gnt_onehot : '0);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_CTRL:   readdata[1] = irq_en_q;
      A_STATUS: readdata[2:0] = {aborted_q, done_flag_q, busy};
      A_DIM:    readdata[DIM_W-1:0] = dim_q;
      A_TILES:  readdata[7:0] = tiles_q;
      A_CYCLES: readdata = cycles_q;
      default:  readdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_novacore_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_novacore_tile_scheduler
// Purpose  : Directed self-checking bench for novacore_tile_scheduler.
//            A per-core responder answers core_start with core_done after a
//            programmable latency; a monitor logs every dispatch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_novacore_tile_scheduler;

  localparam int NC = 4;
  localparam int DW = 4;
  localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_DIM = 3'd2,
                         A_TILES = 3'd3, A_CYCLES = 3'd4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [NC-1:0] core_start;
  logic [DW-1:0] tile_row, tile_col;
  logic [NC-1:0] core_done;
  logic          irq;

  logic [NC-1:0] resp_done = '0;
  logic [NC-1:0] inj_done = '0;
  logic [NC-1:0] resp_en = '0;
  int            resp_lat = 1;
  int            resp_cnt [NC];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wcyc = 0;
  int starts_total = 0;
  int onehot_err = 0;
  int st_core [64];
  int st_row  [64];
  int st_col  [64];
  int st_cyc  [64];

  assign core_done = resp_done | inj_done;

  novacore_tile_scheduler #(.NUM_CORES(NC), .DIM_W(DW)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .core_start(core_start), .tile_row(tile_row), .tile_col(tile_col),
    .core_done(core_done), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < NC; i++) resp_cnt[i] = 0;

  // Responder + dispatch monitor, sampled mid-cycle.
  always @(negedge clk) begin
    resp_done = '0;
    for (int i = 0; i < NC; i++) begin
      if (resp_cnt[i] != 0) begin
        resp_cnt[i] = resp_cnt[i] - 1;
        if (resp_cnt[i] == 0) resp_done[i] = 1'b1;
      end
    end
    if (core_start != '0) begin
      if ($countones(core_start) != 1) onehot_err++;
      for (int i = NC - 1; i >= 0; i--) begin
        if (core_start[i]) begin
          if (resp_en[i]) resp_cnt[i] = resp_lat;
          if (starts_total < 64) st_core[starts_total] = i;
        end
      end
      if (starts_total < 64) begin
        st_row[starts_total] = int'(tile_row);
        st_col[starts_total] = int'(tile_col);
        st_cyc[starts_total] = cyc;
      end
      starts_total++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; inj_done = '0; chipselect = 1'b0; write_n = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    wcyc = cyc;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
  endtask

  task automatic inject(input logic [NC-1:0] m);
    @(posedge clk); #1 inj_done = m;
    @(posedge clk); #1 inj_done = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      address = A_STATUS;
      #1 ok = (readdata[1:0] == 2'b10);
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: job did not finish within %0d cycles (STATUS=%0h)", name, budget, readdata);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_write(A_DIM, 32'd5);
    bus_write(A_CTRL, 32'd2);
    do_reset();
    @(negedge clk);
    n_cmp++; if ({core_start, tile_row, tile_col, irq} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got start=%0h row=%0d col=%0d irq=%0b want all 0", core_start, tile_row, tile_col, irq);
    end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      n_cmp++; if (d !== 32'd0) begin
        n_err++; $display("FAIL reset_reg%0d: got %0h want 0", a, d);
      end
    end
    bus_write(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL undef_addr: got %0h want 0", d); end
    rd(A_DIM, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL undef_write_dim: got %0h want 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int b, w;
    do_reset();
    resp_en = 4'hF; resp_lat = 5;
    bus_write(A_DIM, 32'd2);
    rd(A_DIM, d);
    n_cmp++; if (d !== 32'd2) begin n_err++; $display("FAIL dim_rw: got %0h want 2", d); end
    b = starts_total;
    bus_write(A_CTRL, 32'd1);
    w = wcyc;
    wait_done("basic_done", 100);
    n_cmp++; if (starts_total - b !== 4) begin n_err++; $display("FAIL basic_nstarts: got %0d want 4", starts_total - b); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (st_core[b+k] !== k || st_row[b+k] !== k / 2 || st_col[b+k] !== k % 2 || st_cyc[b+k] !== w + 1 + k) begin
        n_err++;
        $display("FAIL basic_start%0d: got core=%0d tile=(%0d,%0d) cyc=%0d want core=%0d tile=(%0d,%0d) cyc=%0d",
                 k, st_core[b+k], st_row[b+k], st_col[b+k], st_cyc[b+k], k, k / 2, k % 2, w + 1 + k);
      end
    end
    rd(A_TILES, d);
    n_cmp++; if (d !== 32'd4) begin n_err++; $display("FAIL basic_tiles: got %0d want 4", d); end
    rd(A_CYCLES, d);
    n_cmp++; if (d !== 32'd10) begin n_err++; $display("FAIL basic_cycles: got %0d want 10", d); end
    rd(A_STATUS, d);
    n_cmp++; if (d !== 32'd2 || irq !== 1'b0) begin n_err++; $display("FAIL basic_status: got %0h irq=%0b want 2 irq=0", d, irq); end
  endtask

  task automatic test_d0_irq();
    logic [31:0] d;
    int b;
    do_reset();
    bus_write(A_CTRL, 32'd2);
    rd(A_CTRL, d);
    n_cmp++; if (d !== 32'd2) begin n_err++; $display("FAIL ctrl_irq_en: got %0h want 2", d); end
    b = starts_total;
    bus_write(A_CTRL, 32'd3);
    @(negedge clk); address = A_STATUS; #1;
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL d0_status_w1: got %0h want 0", readdata); end
    @(negedge clk); #1;
    n_cmp++; if (readdata !== 32'd2 || irq !== 1'b1) begin
      n_err++; $display("FAIL d0_status_w2: got %0h irq=%0b want 2 irq=1", readdata, irq);
    end
    n_cmp++; if (starts_total !== b) begin n_err++; $display("FAIL d0_nostart: got %0d starts want 0", starts_total - b); end
    rd(A_TILES, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL d0_tiles: got %0d want 0", d); end
    bus_write(A_STATUS, 32'd2);
    rd(A_STATUS, d);
    n_cmp++; if (d !== 32'd0 || irq !== 1'b0) begin n_err++; $display("FAIL w1c_done: got %0h irq=%0b want 0 irq=0", d, irq); end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    int b;
    int exp_core [9] = '{0, 1, 2, 3, 0, 3, 0, 3, 0};
    do_reset();
    resp_en = 4'b1001; resp_lat = 2;
    bus_write(A_DIM, 32'd3);
    b = starts_total;
    bus_write(A_CTRL, 32'd1);
    for (int k = 0; k < 200 && (starts_total - b) < 9; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    n_cmp++; if (starts_total - b !== 9) begin n_err++; $display("FAIL stall_nstarts: got %0d want 9", starts_total - b); end
    rd(A_STATUS, d);
    n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL stall_drain: got %0h want 1", d); end
    rd(A_TILES, d);
    n_cmp++; if (d !== 32'd7) begin n_err++; $display("FAIL stall_tiles7: got %0d want 7", d); end
    bus_write(A_DIM, 32'd7);
    bus_write(A_CTRL, 32'd1);
    rd(A_DIM, d);
    n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL dim_busy_lock: got %0d want 3", d); end
    rd(A_TILES, d);
    n_cmp++; if (d !== 32'd7) begin n_err++; $display("FAIL start_busy_ignored: got %0d want 7", d); end
    inject(4'b0110);
    wait_done("stall_done", 50);
    rd(A_TILES, d);
    n_cmp++; if (d !== 32'd9) begin n_err++; $display("FAIL stall_tiles9: got %0d want 9", d); end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (st_core[b+k] !== exp_core[k] || st_row[b+k] !== k / 3 || st_col[b+k] !== k % 3) begin
        n_err++;
        $display("FAIL stall_start%0d: got core=%0d tile=(%0d,%0d) want core=%0d tile=(%0d,%0d)",
                 k, st_core[b+k], st_row[b+k], st_col[b+k], exp_core[k], k / 3, k % 3);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int b;
    do_reset();
    resp_en = 4'hF; resp_lat = 8;
    bus_write(A_DIM, 32'd4);
    b = starts_total;
    bus_write(A_CTRL, 32'd1);
    repeat (2) @(posedge clk);
    bus_write(A_CTRL, 32'd4);
    wait_done("abort_done", 100);
    n_cmp++; if (starts_total - b !== 3) begin n_err++; $display("FAIL abort_nstarts: got %0d want 3", starts_total - b); end
    rd(A_STATUS, d);
    n_cmp++; if (d !== 32'd6) begin n_err++; $display("FAIL abort_status: got %0h want 6", d); end
    rd(A_TILES, d);
    n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL abort_tiles: got %0d want 3", d); end
    inject(4'b1000);
    rd(A_TILES, d);
    n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL spurious_done: got %0d want 3", d); end
    bus_write(A_CTRL, 32'd4);
    rd(A_STATUS, d);
    n_cmp++; if (d !== 32'd6) begin n_err++; $display("FAIL abort_idle_ignored: got %0h want 6", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int b, w;
    do_reset();
    resp_en = 4'hF; resp_lat = 20;
    bus_write(A_DIM, 32'd2);
    b = starts_total;
    bus_write(A_CTRL, 32'd1);
    for (int k = 0; k < 50 && (starts_total - b) < 4; k++) @(negedge clk);
    rd(A_STATUS, d);
    n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL mid_drain: got %0h want 1", d); end
    do_reset();
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL mid_reset_reg%0d: got %0h want 0", a, d); end
    end
    b = starts_total;
    repeat (25) @(negedge clk);
    rd(A_TILES, d);
    n_cmp++; if (d !== 32'd0 || starts_total !== b) begin
      n_err++; $display("FAIL stale_done: got tiles=%0d starts=%0d want 0 0", d, starts_total - b);
    end
    resp_lat = 3;
    bus_write(A_DIM, 32'd2);
    b = starts_total;
    bus_write(A_CTRL, 32'd1);
    w = wcyc;
    wait_done("rerun_done", 100);
    n_cmp++;
    if (starts_total - b !== 4 || st_core[b] !== 0 || st_row[b] !== 0 || st_col[b] !== 0 || st_cyc[b] !== w + 1) begin
      n_err++;
      $display("FAIL rerun_first: got n=%0d core=%0d tile=(%0d,%0d) cyc=%0d want n=4 core=0 tile=(0,0) cyc=%0d",
               starts_total - b, st_core[b], st_row[b], st_col[b], st_cyc[b], w + 1);
    end
    rd(A_TILES, d);
    n_cmp++; if (d !== 32'd4) begin n_err++; $display("FAIL rerun_tiles: got %0d want 4", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_d0_irq();
    test_stall();
    test_abort();
    test_reset_mid();
    n_cmp++; if (onehot_err !== 0) begin n_err++; $display("FAIL onehot_start: got %0d multi-bit starts want 0", onehot_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
